// File: rtl/serial_word_collector.sv
// rtl/serial_word_collector.sv - collects a serial frame (optional even parity) into a one-deep valid/ready word buffer
module serial_word_collector #(
   parameter int WIDTH     = 4,
   parameter int PARITY_EN = 1
) (
   input  logic             clk,
   input  logic             clear_n,
   input  logic             serial_in,
   input  logic             bit_valid,
   input  logic             select,
   input  logic             start,
   output logic [WIDTH-1:0] data_out,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             parity_err,
   output logic             busy,
   output logic             overrun
);

   localparam int CW = $clog2(WIDTH + 2);
   localparam logic [CW-1:0] LAST_CNT = (PARITY_EN != 0) ? CW'(WIDTH) : CW'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           r_state;
   state_t           w_state_next;
   logic             r_dir;
   logic [WIDTH-1:0] r_sr;
   logic [CW-1:0]    r_cnt;
   logic [WIDTH-1:0] r_data;
   logic             r_valid;
   logic             r_perr;
   logic             r_overrun;

   logic             w_take;
   logic             w_last;
   logic             w_is_par;
   logic             w_free;
   logic [WIDTH-1:0] w_sr_shift;
   logic [WIDTH-1:0] w_final_sr;
   logic             w_final_perr;

   assign w_take       = (r_state == SHIFT) && bit_valid;
   assign w_last       = w_take && (r_cnt == LAST_CNT);
   assign w_is_par     = (PARITY_EN != 0) && (r_cnt == CW'(WIDTH));
   assign w_free       = !r_valid || out_ready;
   assign w_sr_shift   = r_dir ? {serial_in, r_sr[WIDTH-1:1]} : {r_sr[WIDTH-2:0], serial_in};
   // With parity the register is already full when the parity bit arrives; without it the last data bit is still in flight.
   assign w_final_sr   = w_is_par ? r_sr : w_sr_shift;
   assign w_final_perr = (PARITY_EN != 0) ? ^{r_sr, serial_in} : 1'b0;

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         IDLE:    if (start)  w_state_next = SHIFT;
         SHIFT:   if (w_last) w_state_next = IDLE;
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge clear_n) begin
      if (!clear_n) begin
         r_dir     <= 1'b0;
         r_sr      <= '0;
         r_cnt     <= '0;
         r_data    <= '0;
         r_valid   <= 1'b0;
         r_perr    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         if ((r_state == IDLE) && start) begin
            r_dir <= select;
            r_sr  <= '0;
            r_cnt <= '0;
         end else if (w_take && !w_is_par) begin
            r_sr  <= w_sr_shift;
            r_cnt <= r_cnt + 1'b1;
         end

         // A completed word may replace a word being accepted on the same edge.
         if (w_last) begin
            if (w_free) begin
               r_data  <= w_final_sr;
               r_perr  <= w_final_perr;
               r_valid <= 1'b1;
            end else begin
               r_overrun <= 1'b1;
            end
         end else if (r_valid && out_ready) begin
            r_valid <= 1'b0;
         end
      end
   end

   assign data_out   = r_data;
   assign out_valid  = r_valid;
   assign parity_err = r_perr;
   assign busy       = (r_state == SHIFT);
   assign overrun    = r_overrun;

endmodule

// File: tb/tb_serial_word_collector.sv
// tb/tb_serial_word_collector.sv - directed self-checking bench for serial_word_collector
module tb_serial_word_collector;

   logic       clk = 1'b0;
   logic       clear_n = 1'b0;
   logic       serial_in = 1'b0;
   logic       bit_valid = 1'b0;
   logic       select = 1'b0;
   logic       start = 1'b0;
   logic       out_ready = 1'b0;
   logic [3:0] data_out;
   logic       out_valid;
   logic       parity_err;
   logic       busy;
   logic       overrun;

   int checks = 0;
   int failures = 0;

   serial_word_collector #(.WIDTH(4), .PARITY_EN(1)) dut (
      .clk        (clk),
      .clear_n    (clear_n),
      .serial_in  (serial_in),
      .bit_valid  (bit_valid),
      .select     (select),
      .start      (start),
      .data_out   (data_out),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .parity_err (parity_err),
      .busy       (busy),
      .overrun    (overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic sv, input logic bv, input logic st, input logic sel);
      @(negedge clk);
      serial_in = sv;
      bit_valid = bv;
      start     = st;
      select    = sel;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      @(negedge clk);
      clear_n = 1'b0;
      tick();
      @(negedge clk);
      clear_n = 1'b1;
   endtask

   // seq[0] is sent first; seq[4] is the parity bit
   task automatic frame(input logic sel, input logic [4:0] seq, input logic hold_start, input logic rdy_end);
      drive(1'b0, 1'b0, 1'b1, sel);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive(seq[i], 1'b1, hold_start, hold_start ? ~sel : sel);
         if (i == 4) out_ready = rdy_end;
         tick();
      end
      drive(1'b0, 1'b0, 1'b0, sel);
   endtask

   initial begin
      // reset state
      #1;
      chk("rst_data", int'(data_out), 0);
      chk("rst_valid", int'(out_valid), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_overrun", int'(overrun), 0);
      chk("rst_perr", int'(parity_err), 0);
      @(negedge clk);
      clear_n = 1'b1;

      // 1: LSB-first 1,0,1,1 parity 1 -> 1101, no error
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      chk("t1_busy_after_start", int'(busy), 1);
      drive(1'b1, 1'b1, 1'b0, 1'b1); tick();
      drive(1'b0, 1'b1, 1'b0, 1'b1); tick();
      drive(1'b1, 1'b1, 1'b0, 1'b1); tick();
      drive(1'b1, 1'b1, 1'b0, 1'b1); tick();
      chk("t1_valid_before_parity", int'(out_valid), 0);
      chk("t1_busy_before_parity", int'(busy), 1);
      drive(1'b1, 1'b1, 1'b0, 1'b1); tick();
      chk("t1_valid", int'(out_valid), 1);
      chk("t1_data", int'(data_out), 'b1101);
      chk("t1_perr", int'(parity_err), 0);
      chk("t1_busy_end", int'(busy), 0);
      drive(1'b0, 1'b0, 1'b0, 1'b1);
      tick();
      chk("t1_valid_held", int'(out_valid), 1);
      chk("t1_data_held", int'(data_out), 'b1101);
      out_ready = 1'b1;
      tick();
      chk("t1_valid_cleared", int'(out_valid), 0);

      // 2: MSB-first 1,0,0,1 parity 1 -> 1001, parity error
      frame(1'b0, 5'b11001, 1'b0, 1'b1);
      chk("t2_valid", int'(out_valid), 1);
      chk("t2_data", int'(data_out), 'b1001);
      chk("t2_perr", int'(parity_err), 1);

      // 3: select toggling and 3-cycle gaps; latched LSB-first order
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      for (int i = 0; i < 5; i++) begin
         drive((5'b11101 >> i) & 1, 1'b1, 1'b0, i[0]);
         tick();
         if (i < 4) begin
            for (int g = 0; g < 3; g++) begin
               drive(1'b1, 1'b0, 1'b0, ~g[0]);
               tick();
               chk($sformatf("t3_busy_gap%0d_%0d", i, g), int'(busy), 1);
               chk($sformatf("t3_novalid%0d_%0d", i, g), int'(out_valid), 0);
            end
         end
      end
      drive(1'b0, 1'b0, 1'b0, 1'b0);
      chk("t3_valid", int'(out_valid), 1);
      chk("t3_data", int'(data_out), 'b1101);
      chk("t3_perr", int'(parity_err), 0);

      // 4a: buffer full on second frame -> word dropped, overrun
      do_reset();
      out_ready = 1'b0;
      frame(1'b1, 5'b11101, 1'b0, 1'b0);
      chk("t4a_valid1", int'(out_valid), 1);
      chk("t4a_ovr1", int'(overrun), 0);
      frame(1'b1, 5'b00011, 1'b0, 1'b0);
      chk("t4a_data", int'(data_out), 'b1101);
      chk("t4a_valid2", int'(out_valid), 1);
      chk("t4a_overrun", int'(overrun), 1);
      tick();
      chk("t4a_overrun_sticky", int'(overrun), 1);

      // 4b: accept on the frame-end cycle -> new word loads, no overrun
      do_reset();
      chk("t4b_ovr_reset", int'(overrun), 0);
      out_ready = 1'b0;
      frame(1'b1, 5'b11101, 1'b0, 1'b0);
      frame(1'b1, 5'b00011, 1'b0, 1'b1);
      out_ready = 1'b0;
      chk("t4b_data", int'(data_out), 'b0011);
      chk("t4b_valid", int'(out_valid), 1);
      chk("t4b_overrun", int'(overrun), 0);
      chk("t4b_perr", int'(parity_err), 0);

      // 5: reset mid-frame while a word is buffered
      drive(1'b0, 1'b0, 1'b1, 1'b0); tick();
      drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0); tick();
      chk("t5_busy_pre", int'(busy), 1);
      clear_n = 1'b0;
      #1;
      chk("t5_data0", int'(data_out), 0);
      chk("t5_valid0", int'(out_valid), 0);
      chk("t5_busy0", int'(busy), 0);
      chk("t5_perr0", int'(parity_err), 0);
      chk("t5_ovr0", int'(overrun), 0);
      @(negedge clk);
      clear_n   = 1'b1;
      bit_valid = 1'b0;
      out_ready = 1'b1;
      frame(1'b0, 5'b01001, 1'b0, 1'b1);
      chk("t5_data", int'(data_out), 'b1001);
      chk("t5_valid", int'(out_valid), 1);
      chk("t5_perr", int'(parity_err), 0);

      // 6: start held through SHIFT and frame-end cycle is ignored
      frame(1'b0, 5'b00110, 1'b1, 1'b1);
      chk("t6_data", int'(data_out), 'b0110);
      chk("t6_perr", int'(parity_err), 0);
      chk("t6_busy_end", int'(busy), 0);
      tick();
      chk("t6_idle", int'(busy), 0);
      drive(1'b0, 1'b0, 1'b1, 1'b1);
      tick();
      chk("t6_restart", int'(busy), 1);
      drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
      drive(1'b1, 1'b1, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0); tick();
      drive(1'b0, 1'b1, 1'b0, 1'b0); tick();
      chk("t6_data2", int'(data_out), 'b0011);
      chk("t6_valid2", int'(out_valid), 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
